// File: rtl/bus_dma_engine_pkg.sv
// Shared bus constants, FSM state encoding and address helper for the block-copy DMA engine.
package bus_dma_engine_pkg;

   localparam int          BUS_AW         = 32;
   localparam int          BUS_DW         = 32;
   localparam logic [31:0] BUS_WORD_MASK  = 32'hFFFF_FFFC;
   localparam logic [31:0] BUS_WORD_BYTES = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_FIN   = 2'd3
   } dma_state_e;

   function automatic logic [BUS_AW-1:0] word_align(input logic [BUS_AW-1:0] addr);
      return addr & BUS_WORD_MASK;
   endfunction

endpackage

// File: rtl/bus_dma_engine_if.sv
// Single-word shared bus: the initiator drives address/data/strobes, the responder returns data and ready.
interface bus_dma_engine_if;
   import bus_dma_engine_pkg::*;

   logic [BUS_AW-1:0] bus_addr;
   logic [BUS_DW-1:0] bus_wdata;
   logic              bus_rd;
   logic              bus_wr;
   logic [BUS_DW-1:0] bus_rdata;
   logic              bus_ready;

   modport master (
      output bus_addr, bus_wdata, bus_rd, bus_wr,
      input  bus_rdata, bus_ready
   );

   modport slave (
      input  bus_addr, bus_wdata, bus_rd, bus_wr,
      output bus_rdata, bus_ready
   );

endinterface

// File: rtl/bus_dma_engine_watchdog.sv
// Per-transaction watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
// TIMEOUT = 0 disables expiry; the counter saturates so it never wraps into a false expiry.
module bus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic nrst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int            CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_dma_engine.sv
// Word-at-a-time block copy from src to dst over the shared single-word bus, one read then one write per word.
// Zero-wait latency is 3 cycles per word plus one cycle in and one FIN cycle; a stalled bus aborts after TIMEOUT cycles.
module bus_dma_engine
   import bus_dma_engine_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  nrst_i,
   input  logic                  start_i,
   input  logic [BUS_AW-1:0]     src_addr_i,
   input  logic [BUS_AW-1:0]     dst_addr_i,
   input  logic [CNT_W-1:0]      nwords_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [CNT_W-1:0]      words_done_o,
   bus_dma_engine_if.master      bus
);

   dma_state_e        state_q, state_d;
   logic [BUS_AW-1:0] src_q, src_d;
   logic [BUS_AW-1:0] dst_q, dst_d;
   logic [CNT_W-1:0]  nwords_q, nwords_d;
   logic [CNT_W-1:0]  wdone_q, wdone_d;
   logic              err_q, err_d;
   logic              first_q, first_d;
   logic [BUS_AW-1:0] addr_q, addr_d;
   logic [BUS_DW-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              wd_clr, wd_en, wd_expire;

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      nwords_d = nwords_q;
      wdone_d  = wdone_q;
      err_d    = err_q;
      first_d  = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = 1'b0;
      wr_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               src_d    = word_align(src_addr_i);
               dst_d    = word_align(dst_addr_i);
               nwords_d = nwords_i;
               wdone_d  = '0;
               err_d    = 1'b0;
               if (nwords_i == '0) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_READ;
                  addr_d  = word_align(src_addr_i);
                  rd_d    = 1'b1;
                  first_d = 1'b1;
               end
            end
         end

         // The responder's read data is registered, so an ack in the first read cycle carries stale data.
         ST_READ: begin
            if (!first_q && bus.bus_ready) begin
               state_d = ST_WRITE;
               addr_d  = dst_q;
               wdata_d = bus.bus_rdata;
               wr_d    = 1'b1;
            end else if (wd_expire) begin
               state_d = ST_FIN;
               err_d   = 1'b1;
            end else begin
               rd_d = 1'b1;
            end
         end

         ST_WRITE: begin
            if (bus.bus_ready) begin
               wdone_d = wdone_q + CNT_W'(1);
               src_d   = src_q + BUS_WORD_BYTES;
               dst_d   = dst_q + BUS_WORD_BYTES;
               if (wdone_q + CNT_W'(1) == nwords_q) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_READ;
                  addr_d  = src_q + BUS_WORD_BYTES;
                  rd_d    = 1'b1;
                  first_d = 1'b1;
               end
            end else if (wd_expire) begin
               state_d = ST_FIN;
               err_d   = 1'b1;
            end else begin
               wr_d = 1'b1;
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q  <= ST_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         nwords_q <= '0;
         wdone_q  <= '0;
         err_q    <= 1'b0;
         first_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         nwords_q <= nwords_d;
         wdone_q  <= wdone_d;
         err_q    <= err_d;
         first_q  <= first_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   // Every entry into READ or WRITE is a state change, so that alone restarts the transaction timer.
   assign wd_clr = (state_d != state_q) && ((state_d == ST_READ) || (state_d == ST_WRITE));
   assign wd_en  = (state_q == ST_READ) || (state_q == ST_WRITE);

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i    (clk_i),
      .nrst_i   (nrst_i),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );

   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_rd    = rd_q;
   assign bus.bus_wr    = wr_q;

   assign busy_o       = wd_en;
   assign done_o       = (state_q == ST_FIN);
   assign err_o        = err_q;
   assign words_done_o = wdone_q;

endmodule

// File: tb/tb_bus_dma_engine.sv
// Directed + randomized copies against a block-RAM responder (0x4000-0x7FFF) and a word-array copy model.
module tb_bus_dma_engine;
   import bus_dma_engine_pkg::*;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src = '0;
   logic [31:0] dst = '0;
   logic [15:0] nwords = '0;
   logic        busy, done, err;
   logic [15:0] words_done;

   int ncmp = 0;
   int nerr = 0;

   bus_dma_engine_if bus ();

   bus_dma_engine #(.CNT_W(16), .TIMEOUT(TMO)) dut (
      .clk_i        (clk),
      .nrst_i       (nrst),
      .start_i      (start),
      .src_addr_i   (src),
      .dst_addr_i   (dst),
      .nwords_i     (nwords),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .words_done_o (words_done),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   // Block-RAM responder: zero-wait ready, read data registered one edge after the request.
   logic [31:0] mem     [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic        sync_req = 1'b0;
   logic        mapped;

   assign mapped        = (bus.bus_addr[31:14] == 18'd1);
   assign bus.bus_ready = (bus.bus_rd || bus.bus_wr) && mapped;

   always @(posedge clk) begin
      if (sync_req) begin
         for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
      end else begin
         if (bus.bus_rd && mapped) bus.bus_rdata <= mem[bus.bus_addr[13:2]];
         if (bus.bus_wr && mapped) mem[bus.bus_addr[13:2]] <= bus.bus_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Protocol checker: strobes exclusive, address/data held across a continuing request.
   logic        prev_rd = 1'b0, prev_wr = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0;
   always @(negedge clk) begin
      if (nrst) begin
         check("rd_wr_excl", 32'(bus.bus_rd && bus.bus_wr), 32'd0);
         if ((prev_rd && bus.bus_rd) || (prev_wr && bus.bus_wr)) check("addr_stable", bus.bus_addr, prev_addr);
         if (prev_wr && bus.bus_wr) check("wdata_stable", bus.bus_wdata, prev_wdata);
      end
      prev_rd    = bus.bus_rd;
      prev_wr    = bus.bus_wr;
      prev_addr  = bus.bus_addr;
      prev_wdata = bus.bus_wdata;
   end

   task automatic sync_mem();
      @(negedge clk); sync_req = 1'b1;
      @(negedge clk); sync_req = 1'b0;
   endtask

   task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      int si, di;
      si = int'(((s & BUS_WORD_MASK) - 32'h4000) >> 2);
      di = int'(((d & BUS_WORD_MASK) - 32'h4000) >> 2);
      for (int i = 0; i < n; i++) ref_mem[di + i] = ref_mem[si + i];
   endtask

   task automatic check_mem(input string tag);
      int diffs = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check(tag, 32'(diffs), 32'd0);
   endtask

   // lat counts cycles after the start cycle until done is seen.
   task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input bit inject,
                          output int lat, output int rdc, output int wrc, output bit got);
      @(negedge clk); start = 1'b1; src = s; dst = d; nwords = 16'(n);
      @(negedge clk); start = 1'b0;
      lat = 1; rdc = 0; wrc = 0; got = 1'b0;
      if (n != 0) check("busy_on", 32'(busy), 32'd1);
      for (int k = 0; k < 3000 && !got; k++) begin
         if (bus.bus_rd) rdc++;
         if (bus.bus_wr) wrc++;
         if (done) begin
            got = 1'b1;
         end else begin
            if (inject && lat == 3) begin
               start = 1'b1; src = 32'h4400; dst = 32'h4500; nwords = 16'd2;
            end else begin
               start = 1'b0;
            end
            @(negedge clk); lat++;
         end
      end
      start = 1'b0;
      check("done_seen", 32'(got), 32'd1);
      if (got) check("busy_at_done", 32'(busy), 32'd0);
   endtask

   // A zero-wait copy of n words finishes with done in cycle 3n+2, counting the start cycle as 1.
   task automatic normal_xfer(input string tag, input logic [31:0] s, input logic [31:0] d, input int n, input bit inject);
      int lat, rdc, wrc;
      bit got;
      do_xfer(s, d, n, inject, lat, rdc, wrc, got);
      model_copy(s, d, n);
      check({tag, "_cycle"}, 32'(lat + 1), 32'(3 * n + 2));
      check({tag, "_rd_cycles"}, 32'(rdc), 32'(2 * n));
      check({tag, "_wr_cycles"}, 32'(wrc), 32'(n));
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_words_done"}, 32'(words_done), 32'(n));
      check_mem({tag, "_mem"});
   endtask

   initial begin
      int lat, rdc, wrc;
      bit got, seen;
      logic [31:0] s, d;
      int n;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_wdone", 32'(words_done), 32'd0);
      check("rst_rdwr", 32'({bus.bus_rd, bus.bus_wr}), 32'd0);
      check("rst_addr", bus.bus_addr, 32'd0);

      for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
      ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33; ref_mem[3] = 32'h44;
      sync_mem();
      @(negedge clk); nrst = 1'b1;
      repeat (2) @(negedge clk);

      normal_xfer("copy4", 32'h4000, 32'h4100, 4, 1'b0);
      check("copy4_w3", mem[32'h43], 32'h44);

      normal_xfer("zero", 32'h4000, 32'h4200, 0, 1'b0);

      // Overlapping forward copy must replicate the first word.
      ref_mem[0] = 32'hA5;
      sync_mem();
      normal_xfer("raw", 32'h4000, 32'h4004, 3, 1'b0);
      check("raw_last", mem[3], 32'hA5);

      do_xfer(32'h8000, 32'h4000, 3, 1'b0, lat, rdc, wrc, got);
      check("tmo_cycle", 32'(lat + 1), 32'(TMO + 2));
      check("tmo_rd_cycles", 32'(rdc), 32'(TMO));
      check("tmo_wr_cycles", 32'(wrc), 32'd0);
      check("tmo_err", 32'(err), 32'd1);
      check("tmo_words_done", 32'(words_done), 32'd0);
      check_mem("tmo_mem");
      @(negedge clk);
      check("tmo_err_held", 32'(err), 32'd1);

      // Reset during the third word's write phase.
      @(negedge clk); start = 1'b1; src = 32'h4800; dst = 32'h4900; nwords = 16'd5;
      @(negedge clk); start = 1'b0;
      check("rst_err_cleared", 32'(err), 32'd0);
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         if (bus.bus_wr && words_done == 16'd2) got = 1'b1;
         else @(negedge clk);
      end
      check("rst_reach_w3", 32'(got), 32'd1);
      #1 nrst = 1'b0;
      #1;
      check("arst_rdwr", 32'({bus.bus_rd, bus.bus_wr}), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_wdone", 32'(words_done), 32'd0);
      check("arst_addr", bus.bus_addr, 32'd0);
      seen = 1'b0;
      repeat (2) begin @(negedge clk); if (done) seen = 1'b1; end
      nrst = 1'b1;
      repeat (4) begin @(negedge clk); if (done) seen = 1'b1; end
      check("arst_no_done", 32'(seen), 32'd0);
      model_copy(32'h4800, 32'h4900, 2);
      check_mem("arst_partial_mem");
      normal_xfer("post_rst", 32'h4A00, 32'h4B00, 4, 1'b0);

      normal_xfer("ignore_start", 32'h4200, 32'h4300, 5, 1'b1);

      for (int t = 0; t < 6; t++) begin
         s = 32'h4000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
         d = 32'h4000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
         n = int'($urandom_range(1, 10));
         normal_xfer("rand", s, d, n, 1'b0);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global time limit");
   end

endmodule
